fwd_hazard_unit: RTL and testbench

//  Decode-stage forwarding and hazard control for the 5-stage RV32I pipeline.
//  - Compares ID source registers against the EX/MEM destinations.
//  - Registers the 3-bit ALU/branch operand selects into the ID/EX boundary, so they are valid in EX alongside the operands.
//  - Detects load-use hazards and dmem wait, and drives PC / IF-ID / ID-EX enables and bubbles.
//  - Counts stall cycles.

---
 rtl/fwd_hazard_unit_pkg.sv | 28 ++
 rtl/fwd_hazard_unit_if.sv | 49 ++++
 rtl/fwd_hazard_unit_fwd_compare.sv | 30 +++
 rtl/fwd_hazard_unit.sv | 132 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline-control types: operand-select encodings, hazard FSM states
// and the per-source forwarding compare result.
package pipe_ctrl_pkg;

    localparam int RA_W_DEF = 5;

    localparam logic [2:0] SEL_REG = 3'b100;
    localparam logic [2:0] SEL_IMM = 3'b000;
    localparam logic [2:0] SEL_MEM = 3'b110;
    localparam logic [2:0] SEL_WB  = 3'b101;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // sel[1:0] is the low part of a register-path select: 10=MEM, 01=WB, 00=reg
    typedef struct packed {
        logic       hit_e;
        logic [1:0] sel;
    } fwd_res_t;

    function automatic logic [2:0] reg_sel(input logic [1:0] s);
        return {1'b1, s};
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-stage hazard bus: ID/EX/MEM status into the unit, pipeline
// enables, registered operand selects and the stall counter out.
interface fwd_hazard_unit_if
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W  = RA_W_DEF,
    parameter int CNT_W = 32
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_src2_imm;
    logic            ex_valid;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            mem_valid;
    logic [RA_W-1:0] mem_rd;
    logic            mem_reg_write;
    logic            mem_wait;
    logic            flush;

    logic             pc_write_en;
    logic             ifid_write_en;
    logic             idex_write_en;
    logic             idex_bubble;
    logic [2:0]       ex_src1_sel;
    logic [2:0]       ex_src2_sel;
    logic [2:0]       ex_bsrc_sel;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_src2_imm, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
        output mem_valid, mem_rd, mem_reg_write, mem_wait, flush,
        input  pc_write_en, ifid_write_en, idex_write_en, idex_bubble,
        input  ex_src1_sel, ex_src2_sel, ex_bsrc_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_src2_imm, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
        input  mem_valid, mem_rd, mem_reg_write, mem_wait, flush,
        output pc_write_en, ifid_write_en, idex_write_en, idex_bubble,
        output ex_src1_sel, ex_src2_sel, ex_bsrc_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit_fwd_compare.sv
// One ID source register against the EX and MEM destinations.
// x0 never matches; EX takes precedence over MEM.
module fwd_compare
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] i_r,
    input  logic            i_use,
    input  logic            i_ex_valid,
    input  logic            i_ex_reg_write,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic            i_mem_valid,
    input  logic            i_mem_reg_write,
    input  logic [RA_W-1:0] i_mem_rd,
    output fwd_res_t        o_res
);
    logic w_live;
    logic w_hit_e;
    logic w_hit_m;

    assign w_live  = i_use & (|i_r);
    assign w_hit_e = w_live & i_ex_valid & i_ex_reg_write
                   & (i_ex_rd == i_r);
    assign w_hit_m = w_live & i_mem_valid & i_mem_reg_write
                   & (i_mem_rd == i_r);

    assign o_res.hit_e = w_hit_e;
    assign o_res.sel   = w_hit_e ? 2'b10 : (w_hit_m ? 2'b01 : 2'b00);
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select generation, load-use / dmem-wait hazard FSM and a
// saturating stall-cycle counter for the ID/EX boundary.
module fwd_hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W  = RA_W_DEF,
    parameter int CNT_W = 32
) (
    input logic               CLK,
    input logic               RST,
    fwd_hazard_unit_if.slave  bus
);
    fwd_res_t         w_rs1;
    fwd_res_t         w_rs2;
    logic             w_lu;
    logic             w_lu_stall;
    hz_state_t        r_state;
    hz_state_t        w_next;
    logic             w_pc_en;
    logic             w_ifid_en;
    logic             w_idex_en;
    logic             w_bubble;
    logic             r_bubble;
    logic [2:0]       w_src1;
    logic [2:0]       w_src2;
    logic [2:0]       w_bsrc;
    logic [2:0]       r_src1;
    logic [2:0]       r_src2;
    logic [2:0]       r_bsrc;
    logic [CNT_W-1:0] r_cnt;

    fwd_compare #(.RA_W(RA_W)) u_cmp_rs1 (
        .i_r            (bus.id_rs1),
        .i_use          (bus.id_use_rs1),
        .i_ex_valid     (bus.ex_valid),
        .i_ex_reg_write (bus.ex_reg_write),
        .i_ex_rd        (bus.ex_rd),
        .i_mem_valid    (bus.mem_valid),
        .i_mem_reg_write(bus.mem_reg_write),
        .i_mem_rd       (bus.mem_rd),
        .o_res          (w_rs1)
    );

    fwd_compare #(.RA_W(RA_W)) u_cmp_rs2 (
        .i_r            (bus.id_rs2),
        .i_use          (bus.id_use_rs2),
        .i_ex_valid     (bus.ex_valid),
        .i_ex_reg_write (bus.ex_reg_write),
        .i_ex_rd        (bus.ex_rd),
        .i_mem_valid    (bus.mem_valid),
        .i_mem_reg_write(bus.mem_reg_write),
        .i_mem_rd       (bus.mem_rd),
        .o_res          (w_rs2)
    );

    assign w_lu = bus.id_valid & bus.ex_mem_read
                & (w_rs1.hit_e | w_rs2.hit_e);

    // After LU_STALL the load has moved to MEM, so lu there is stale
    assign w_lu_stall = w_lu & (r_state != LU_STALL);

    assign w_src1 = reg_sel(w_rs1.sel);
    assign w_src2 = bus.id_src2_imm ? SEL_IMM : reg_sel(w_rs2.sel);
    assign w_bsrc = reg_sel(w_rs2.sel);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= RUN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.mem_wait)   w_next = MEM_WAIT;
        else if (bus.flush) w_next = RUN;
        else if (w_lu_stall) w_next = LU_STALL;
        else                w_next = RUN;
    end

    always_comb begin
        w_pc_en   = 1'b1;
        w_ifid_en = 1'b1;
        w_idex_en = 1'b1;
        w_bubble  = 1'b0;
        if (RST) begin
            w_pc_en   = 1'b0;
            w_ifid_en = 1'b0;
            w_bubble  = 1'b1;
        end else if (bus.mem_wait) begin
            w_pc_en   = 1'b0;
            w_ifid_en = 1'b0;
            w_idex_en = 1'b0;
            w_bubble  = r_bubble;
        end else if (bus.flush) begin
            w_bubble  = 1'b1;
        end else if (w_lu_stall) begin
            w_pc_en   = 1'b0;
            w_ifid_en = 1'b0;
            w_bubble  = 1'b1;
        end
    end

    // A bubble into ID/EX always carries register selects
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_src1   <= SEL_REG;
            r_src2   <= SEL_REG;
            r_bsrc   <= SEL_REG;
            r_bubble <= 1'b1;
        end else if (!bus.mem_wait) begin
            r_src1   <= w_bubble ? SEL_REG : w_src1;
            r_src2   <= w_bubble ? SEL_REG : w_src2;
            r_bsrc   <= w_bubble ? SEL_REG : w_bsrc;
            r_bubble <= w_bubble;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_cnt <= '0;
        else if (!w_pc_en && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign bus.pc_write_en   = w_pc_en;
    assign bus.ifid_write_en = w_ifid_en;
    assign bus.idex_write_en = w_idex_en;
    assign bus.idex_bubble   = w_bubble;
    assign bus.ex_src1_sel   = r_src1;
    assign bus.ex_src2_sel   = r_src2;
    assign bus.ex_bsrc_sel   = r_bsrc;
    assign bus.stall_cnt     = r_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Vector table plus hand sequences for fwd_hazard_unit; registered selects
// go through an expectation queue, comb outputs are checked mid-cycle.
module tb_fwd_hazard_unit;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] I = 3'b000;
    localparam logic [2:0] M = 3'b110;
    localparam logic [2:0] W = 3'b101;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    typedef struct packed {
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       imm;
        logic       exv;
        logic [4:0] exrd;
        logic       exrw;
        logic       exmr;
        logic       mv;
        logic [4:0] mrd;
        logic       mrw;
        logic       mw;
        logic       fl;
        logic       pc;
        logic       ifid;
        logic       idex;
        logic       bub;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [2:0] bs;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [8:0] sb[$];
    vec_t tbl[15];

    fwd_hazard_unit_if #(.RA_W(5), .CNT_W(CW)) bus ();

    fwd_hazard_unit #(.RA_W(5), .CNT_W(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid      = v.idv;
        bus.id_rs1        = v.rs1;
        bus.id_rs2        = v.rs2;
        bus.id_use_rs1    = v.u1;
        bus.id_use_rs2    = v.u2;
        bus.id_src2_imm   = v.imm;
        bus.ex_valid      = v.exv;
        bus.ex_rd         = v.exrd;
        bus.ex_reg_write  = v.exrw;
        bus.ex_mem_read   = v.exmr;
        bus.mem_valid     = v.mv;
        bus.mem_rd        = v.mrd;
        bus.mem_reg_write = v.mrw;
        bus.mem_wait      = v.mw;
        bus.flush         = v.fl;
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] e;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " ex_src1_sel"}, 32'(bus.ex_src1_sel), 32'(e[8:6]));
            chk({tag, " ex_src2_sel"}, 32'(bus.ex_src2_sel), 32'(e[5:3]));
            chk({tag, " ex_bsrc_sel"}, 32'(bus.ex_bsrc_sel), 32'(e[2:0]));
        end
        chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_cnt));
    endtask

    // Called one time unit after a rising edge
    task automatic step(input string tag, input vec_t v);
        drive(v);
        #3;
        chk({tag, " pc_write_en"}, 32'(bus.pc_write_en), 32'(v.pc));
        chk({tag, " ifid_write_en"}, 32'(bus.ifid_write_en), 32'(v.ifid));
        chk({tag, " idex_write_en"}, 32'(bus.idex_write_en), 32'(v.idex));
        chk({tag, " idex_bubble"}, 32'(bus.idex_bubble), 32'(v.bub));
        sb.push_back({v.s1, v.s2, v.bs});
        if (!v.pc && exp_cnt != CMAX) exp_cnt = exp_cnt + 1'b1;
        @(posedge CLK);
        #1;
        pop_check(tag);
    endtask

    initial begin
        vec_t a_lu, a_mw, a_res, b_lw, b_lu, b_ld, b_sat;

        tbl[0]  = '{F,5'd0,5'd0,F,F,F, F,5'd0,F,F, F,5'd0,F, F,F, T,T,T,F, R,R,R};
        tbl[1]  = '{T,5'd5,5'd5,T,T,F, T,5'd5,T,F, F,5'd0,F, F,F, T,T,T,F, M,M,M};
        tbl[2]  = '{T,5'd7,5'd0,T,F,T, F,5'd0,F,F, T,5'd7,T, F,F, T,T,T,F, W,I,R};
        tbl[3]  = '{T,5'd0,5'd0,T,T,F, T,5'd0,T,T, T,5'd0,T, F,F, T,T,T,F, R,R,R};
        tbl[4]  = '{T,5'd9,5'd9,T,T,F, T,5'd9,T,F, T,5'd9,T, F,F, T,T,T,F, M,M,M};
        tbl[5]  = '{T,5'd11,5'd10,T,T,T, T,5'd11,F,F, T,5'd10,T, F,F, T,T,T,F, R,I,W};
        tbl[6]  = '{T,5'd12,5'd0,T,F,F, F,5'd12,T,T, T,5'd12,F, F,F, T,T,T,F, R,R,R};
        tbl[7]  = '{T,5'd13,5'd0,F,F,F, T,5'd13,T,T, F,5'd0,F, F,F, T,T,T,F, R,R,R};
        tbl[8]  = '{T,5'd3,5'd0,T,T,F, T,5'd3,T,T, F,5'd0,F, F,F, F,F,T,T, R,R,R};
        tbl[9]  = '{T,5'd3,5'd0,T,T,F, F,5'd0,F,F, T,5'd3,T, F,F, T,T,T,F, W,R,R};
        tbl[10] = '{F,5'd3,5'd0,T,F,F, T,5'd3,T,T, F,5'd0,F, F,F, T,T,T,F, M,R,R};
        tbl[11] = '{T,5'd4,5'd0,T,F,F, T,5'd4,T,T, F,5'd0,F, F,T, T,T,T,T, R,R,R};
        tbl[12] = '{T,5'd0,5'd8,F,T,F, T,5'd8,T,T, F,5'd0,F, F,F, F,F,T,T, R,R,R};
        tbl[13] = '{T,5'd0,5'd8,F,T,F, T,5'd8,T,T, F,5'd0,F, F,F, T,T,T,F, R,M,M};
        tbl[14] = '{T,5'd5,5'd0,T,F,F, T,5'd5,T,F, F,5'd0,F, F,T, T,T,T,T, R,R,R};

        a_lu  = '{T,5'd3,5'd0,T,T,F, T,5'd3,T,T, F,5'd0,F, F,F, F,F,T,T, R,R,R};
        a_mw  = '{T,5'd3,5'd0,T,T,F, F,5'd0,F,F, T,5'd3,T, T,F, F,F,F,T, R,R,R};
        a_res = '{T,5'd3,5'd0,T,T,F, F,5'd0,F,F, T,5'd3,T, F,F, T,T,T,F, W,R,R};
        b_lw  = '{T,5'd3,5'd0,T,T,F, T,5'd3,T,T, F,5'd0,F, T,F, F,F,F,F, W,R,R};
        b_lu  = '{T,5'd3,5'd0,T,T,F, T,5'd3,T,T, F,5'd0,F, F,F, F,F,T,T, R,R,R};
        b_ld  = '{T,5'd3,5'd0,T,T,F, F,5'd0,F,F, T,5'd3,T, F,F, T,T,T,F, W,R,R};
        b_sat = '{T,5'd3,5'd0,T,T,F, F,5'd0,F,F, T,5'd3,T, T,F, F,F,F,F, W,R,R};

        drive(tbl[0]);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst pc_write_en", 32'(bus.pc_write_en), 32'd0);
        chk("rst ifid_write_en", 32'(bus.ifid_write_en), 32'd0);
        chk("rst idex_write_en", 32'(bus.idex_write_en), 32'd1);
        chk("rst idex_bubble", 32'(bus.idex_bubble), 32'd1);
        chk("rst ex_src1_sel", 32'(bus.ex_src1_sel), 32'(R));
        chk("rst ex_src2_sel", 32'(bus.ex_src2_sel), 32'(R));
        chk("rst ex_bsrc_sel", 32'(bus.ex_bsrc_sel), 32'(R));
        chk("rst stall_cnt", 32'(bus.stall_cnt), 32'd0);
        RST = 1'b0;

        for (int i = 0; i < 15; i++)
            step($sformatf("tbl%0d", i), tbl[i]);

        step("lu_a", a_lu);
        for (int i = 0; i < 3; i++)
            step($sformatf("mw_a%0d", i), a_mw);
        step("resume_a", a_res);

        step("mw_lu_b", b_lw);
        step("relu_b", b_lu);
        step("ld_mem_b", b_ld);

        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), b_sat);

        step("lu_c", a_lu);
        step("mw_c", a_mw);
        RST = 1'b1;
        #3;
        chk("rst_mid pc_write_en", 32'(bus.pc_write_en), 32'd0);
        chk("rst_mid ifid_write_en", 32'(bus.ifid_write_en), 32'd0);
        chk("rst_mid idex_write_en", 32'(bus.idex_write_en), 32'd1);
        chk("rst_mid idex_bubble", 32'(bus.idex_bubble), 32'd1);
        sb.push_back({R, R, R});
        exp_cnt = '0;
        @(posedge CLK);
        #1;
        pop_check("rst_mid");
        RST = 1'b0;
        step("post_rst", tbl[0]);
        step("post_rst_fwd", tbl[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
